// File: rtl/imm_gen_pipe.sv
// Purpose: RISC-V immediate extraction/extension (I/S/B/J/U/Z, optional RVC) behind a 2-entry output buffer.
// Latency: 1 cycle from input acceptance to out_* when the buffer is empty.
// Backpressure: in_ready is registered (!full) and independent of out_ready; define IMM_GEN_RVC_EN for compressed decode.
module imm_gen_pipe #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned DECODE_OPCODE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [2:0]      in_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [2:0] FMT_I   = 3'b000;
    localparam logic [2:0] FMT_S   = 3'b001;
    localparam logic [2:0] FMT_B   = 3'b010;
    localparam logic [2:0] FMT_J   = 3'b011;
    localparam logic [2:0] FMT_U   = 3'b100;
    localparam logic [2:0] FMT_Z   = 3'b101;
    localparam logic [2:0] FMT_C   = 3'b110;
    localparam logic [2:0] FMT_ILL = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } ent_t;

    logic [31:0] imm32;
    logic [2:0]  dec_typ;
    logic        dec_ill;
    logic [2:0]  fmt;
    logic        fmt_ok;
    ent_t        dec_ent;

    ent_t        slot0_q, slot0_d;
    ent_t        slot1_q, slot1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        rdy_q, rdy_d;
    logic        push, pop;

    // Decode the format and build a 32-bit immediate; every format is
    // either sign-extended or has bit 31 clear, so one sign-extension to
    // XLEN covers all of them.
    always_comb begin
        imm32   = '0;
        dec_typ = FMT_ILL;
        dec_ill = 1'b1;
        fmt     = FMT_I;
        fmt_ok  = 1'b0;
        if (DECODE_OPCODE != 0) begin
            if (in_instr[1:0] == 2'b11) begin
                fmt_ok = 1'b1;
                case (in_instr[6:0])
                    7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
                    7'b0100011:                         fmt = FMT_S;
                    7'b1100011:                         fmt = FMT_B;
                    7'b1101111:                         fmt = FMT_J;
                    7'b0110111, 7'b0010111:             fmt = FMT_U;
                    7'b1110011:                         fmt = in_instr[14] ? FMT_Z : FMT_I;
                    default:                            fmt_ok = 1'b0;
                endcase
            end else begin
`ifdef IMM_GEN_RVC_EN
                dec_typ = FMT_C;
                dec_ill = 1'b0;
                case ({in_instr[1:0], in_instr[15:13]})
                    5'b01_000, 5'b01_010:
                        imm32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
                    5'b01_101:
                        imm32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8], in_instr[10:9],
                                 in_instr[6], in_instr[7], in_instr[2], in_instr[11],
                                 in_instr[5:3], 1'b0};
                    5'b01_110, 5'b01_111:
                        imm32 = {{23{in_instr[12]}}, in_instr[12], in_instr[6:5], in_instr[2],
                                 in_instr[11:10], in_instr[4:3], 1'b0};
                    5'b00_010, 5'b00_110:
                        imm32 = {25'b0, in_instr[5], in_instr[12:10], in_instr[6], 2'b00};
                    default: begin
                        imm32   = '0;
                        dec_typ = FMT_ILL;
                        dec_ill = 1'b1;
                    end
                endcase
`endif
            end
        end else begin
            // Select mode: opcode bits are ignored entirely.
            fmt    = in_sel;
            fmt_ok = (in_sel <= FMT_Z);
        end

        if (fmt_ok) begin
            dec_typ = fmt;
            dec_ill = 1'b0;
            case (fmt)
                FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
                FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
                FMT_U:   imm32 = {in_instr[31:12], 12'b0};
                FMT_Z:   imm32 = {27'b0, in_instr[19:15]};
                default: imm32 = '0;
            endcase
        end

        dec_ent.imm = XLEN'($signed(imm32));
        dec_ent.typ = dec_typ;
        dec_ent.ill = dec_ill;
    end

    assign push = in_valid & rdy_q;
    assign pop  = out_valid & out_ready;

    // Two-entry in-order buffer: slot0 is the head, slot1 the tail.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        if (pop) begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == 2'd0) begin
                slot0_d = dec_ent;
            end else begin
                slot1_d = dec_ent;
            end
            cnt_d = cnt_d + 2'd1;
        end
        // Flush discards both entries and any same-cycle push.
        if (flush) begin
            cnt_d = 2'd0;
        end
        rdy_d = (cnt_d != 2'd2);
    end

    // State update; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            cnt_q   <= 2'd0;
            rdy_q   <= 1'b1;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (cnt_q != 2'd0);
    assign out_imm     = out_valid ? slot0_q.imm : '0;
    assign out_type    = out_valid ? slot0_q.typ : 3'b000;
    assign out_illegal = out_valid & slot0_q.ill;

endmodule
